byte_access_ctrl: RTL and testbench
===================================

// Module: byte_access_ctrl
// PURPOSE
//   Byte access controller between the CPU data path and the word-wide data memory.
//   Word mode passes address and data through unchanged.
//   Byte mode:
//   - word-aligns the address;
//   - merges the store byte into the memory read word (read-modify-write store data);
//   - extracts the addressed byte of the read word as load data.
//   Also flags misaligned word accesses and keeps a sticky error bit.
// PARAMETERS
//   (none) - widths fixed: 32-bit address, 32-bit data.
// PORTS
//   clk        in   1   system clock; only the sticky error register uses it
//   rst_n      in   1   reset; asynchronous, active-low
//   BACOp      in   1   access size: `BAC_OP_WORD = 1'b0, `BAC_OP_BYTE = 1'b1
//   Ain        in   32  CPU byte address
//   Din1       in   32  CPU store data; byte mode uses Din1[7:0] only
//   Din2       in   32  word read from memory at Aout
//   Aout       out  32  address to memory
//   Dout1      out  32  write word to memory
//   Dout2      out  32  load data to CPU
//   AlignErr   out  1   combinational misaligned-word flag
//   ErrSticky  out  1   registered, sticky OR of AlignErr
// BEHAVIOUR
//   - One clock (clk); reset rst_n is asynchronous, active-low.
//   - Aout, Dout1, Dout2, AlignErr: purely combinational, zero latency.
//     Valid within the same delta/propagation after any input change; no clock involvement.
//   - WORD (BACOp=0):
//     - Aout = Ain, Dout1 = Din1, Dout2 = Din2.
//     - AlignErr = (Ain[1:0] != 2'b00). Address is NOT realigned.
//   - BYTE (BACOp=1): let k = Ain[1:0], little-endian byte lanes (lane 0 = bits[7:0]).
//     - Aout = {Ain[31:2], 2'b00}.
//     - Dout1 = Din2 with lane k replaced by Din1[7:0]; other three lanes from Din2 unchanged.
//     - Dout2 = {24'b0, Din2 lane k}: zero-extended (no sign extension).
//     - AlignErr = 0; any byte address is legal.
//   - BACOp = X/Z: outputs are don't-care; the implementation must not latch.
//   - ErrSticky:
//     - cleared to 0 asynchronously when rst_n=0;
//     - on each posedge clk with rst_n=1: ErrSticky <= ErrSticky | AlignErr;
//     - once set, stays 1 until reset.
//   - Reset values: ErrSticky=0. Combinational outputs follow inputs even during reset.
//   - Reset asserted mid-operation clears ErrSticky immediately and does not affect the data path.
//   - Address wrap: byte mode at Ain=32'hFFFF_FFFF gives Aout=32'hFFFF_FFFC; no carry, no error.
// TESTING
//   1. Word: BACOp=0, Ain=32'h1234_5678, Din1=32'h1212_3434, Din2=32'h7878_7878
//      -> Aout=32'h1234_5678, Dout1=32'h1212_3434, Dout2=32'h7878_7878, AlignErr=0.
//   2. Byte lane 1: BACOp=1, Ain=32'h41, Din1=32'h1234_5678, Din2=32'h7890_1234
//      -> Aout=32'h40, Dout1=32'h7890_7834, Dout2=32'h12.
//   3. All lanes: BACOp=1, Din1=32'hAA, Din2=32'h8877_6655, Ain[1:0]=0..3
//      -> Dout1 = 8877_66AA / 8877_AA55 / 88AA_6655 / AA77_6655;
//         Dout2 = 55 / 66 / 77 / 88 (zero-extended; 32'h88 must not become FFFF_FF88).
//   4. Misaligned word: BACOp=0, Ain=32'h1002 -> AlignErr=1, Aout=32'h1002;
//      after a posedge clk, ErrSticky=1; it stays 1 after returning to Ain=32'h1000.
//   5. Reset: with ErrSticky=1, drop rst_n between clock edges -> ErrSticky=0 immediately;
//      it stays 0 while rst_n=0 even with AlignErr=1.
//   6. Wrap: BACOp=1, Ain=32'hFFFF_FFFF, Din2=32'h1122_3344 -> Aout=32'hFFFF_FFFC, Dout2=32'h11.

Source files
------------

// File: rtl/byte_access_ctrl.sv
// Byte access controller: passes word accesses straight through, and in byte mode
// word-aligns the address, merges the store byte into the read word and extracts the load byte.
module byte_access_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        BACOp,
  input  logic [31:0] Ain,
  input  logic [31:0] Din1,
  input  logic [31:0] Din2,
  output logic [31:0] Aout,
  output logic [31:0] Dout1,
  output logic [31:0] Dout2,
  output logic        AlignErr,
  output logic        ErrSticky
);

  localparam logic BAC_OP_WORD = 1'b0;
  localparam logic BAC_OP_BYTE = 1'b1;

  logic [1:0]  lane;
  logic [7:0]  load_byte;
  logic [31:0] merged_word;
  logic        err_sticky_q;
  logic        err_sticky_d;

  assign lane = Ain[1:0];

  // Lane selection is written as explicit cases so every path assigns a full value.
  always_comb begin
    merged_word = Din2;
    load_byte   = Din2[7:0];
    case (lane)
      2'd0: begin
        merged_word[7:0] = Din1[7:0];
        load_byte        = Din2[7:0];
      end
      2'd1: begin
        merged_word[15:8] = Din1[7:0];
        load_byte         = Din2[15:8];
      end
      2'd2: begin
        merged_word[23:16] = Din1[7:0];
        load_byte          = Din2[23:16];
      end
      default: begin
        merged_word[31:24] = Din1[7:0];
        load_byte          = Din2[31:24];
      end
    endcase
  end

  // Word mode is the default, so an unknown BACOp resolves to a plain assignment, never a latch.
  always_comb begin
    Aout     = Ain;
    Dout1    = Din1;
    Dout2    = Din2;
    AlignErr = (lane != 2'b00);
    if (BACOp == BAC_OP_BYTE) begin
      Aout     = {Ain[31:2], 2'b00};
      Dout1    = merged_word;
      Dout2    = {24'b0, load_byte};
      AlignErr = 1'b0;
    end else if (BACOp != BAC_OP_WORD) begin
      AlignErr = 1'b0;
    end
  end

  assign err_sticky_d = err_sticky_q | AlignErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign ErrSticky = err_sticky_q;

endmodule

// File: tb/tb_byte_access_ctrl.sv
// Directed bench for byte_access_ctrl: the driver pushes hand-computed expectations into a
// queue and a negedge monitor pops and compares them against the DUT outputs.
module tb_byte_access_ctrl;

  localparam int W = 98;

  logic        clk;
  logic        rst_n;
  logic        BACOp;
  logic [31:0] Ain;
  logic [31:0] Din1;
  logic [31:0] Din2;
  logic [31:0] Aout;
  logic [31:0] Dout1;
  logic [31:0] Dout2;
  logic        AlignErr;
  logic        ErrSticky;

  // Entry layout: {aout[97:66], dout1[65:34], dout2[33:2], align_err[1], err_sticky[0]}
  logic [W-1:0] exp_q[$];
  string        name_q[$];

  int n_cmp;
  int n_err;

  logic        model_sticky;
  logic        last_align;
  logic [31:0] last_aout;
  logic [31:0] last_d1;
  logic [31:0] last_d2;

  byte_access_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .BACOp    (BACOp),
    .Ain      (Ain),
    .Din1     (Din1),
    .Din2     (Din2),
    .Aout     (Aout),
    .Dout1    (Dout1),
    .Dout2    (Dout2),
    .AlignErr (AlignErr),
    .ErrSticky(ErrSticky)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard helpers
  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: actual=%h required=%h", name, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, "Aout",      Aout,               e[97:66]);
      check(nm, "Dout1",     Dout1,              e[65:34]);
      check(nm, "Dout2",     Dout2,              e[33:2]);
      check(nm, "AlignErr",  {31'b0, AlignErr},  {31'b0, e[1]});
      check(nm, "ErrSticky", {31'b0, ErrSticky}, {31'b0, e[0]});
    end
  end

  // Driver tasks
  task automatic drive(input string name, input logic op, input logic [31:0] ain,
                       input logic [31:0] din1, input logic [31:0] din2,
                       input logic [31:0] e_aout, input logic [31:0] e_d1,
                       input logic [31:0] e_d2, input logic e_align);
    @(posedge clk);
    if (rst_n) model_sticky = model_sticky | last_align;
    #1;
    BACOp = op;
    Ain   = ain;
    Din1  = din1;
    Din2  = din2;
    last_align = e_align;
    last_aout  = e_aout;
    last_d1    = e_d1;
    last_d2    = e_d2;
    exp_q.push_back({e_aout, e_d1, e_d2, e_align, model_sticky});
    name_q.push_back(name);
  endtask

  // Asserts reset between edges; data outputs must be unchanged, ErrSticky cleared at once.
  task automatic drop_reset(input string name);
    @(posedge clk);
    if (rst_n) model_sticky = model_sticky | last_align;
    #2;
    rst_n = 1'b0;
    model_sticky = 1'b0;
    exp_q.push_back({last_aout, last_d1, last_d2, last_align, model_sticky});
    name_q.push_back(name);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_sticky = 1'b0;
    last_align = 1'b0;
    last_aout = '0;
    last_d1 = '0;
    last_d2 = '0;
    rst_n = 1'b0;
    BACOp = 1'b0;
    Ain   = '0;
    Din1  = '0;
    Din2  = '0;

    drive("reset_state", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    drive("word", 1'b0, 32'h1234_5678, 32'h1212_3434, 32'h7878_7878,
          32'h1234_5678, 32'h1212_3434, 32'h7878_7878, 1'b0);
    drive("byte_lane1", 1'b1, 32'h0000_0041, 32'h1234_5678, 32'h7890_1234,
          32'h0000_0040, 32'h7890_7834, 32'h0000_0012, 1'b0);
    drive("lane0", 1'b1, 32'h0000_0100, 32'h0000_00AA, 32'h8877_6655,
          32'h0000_0100, 32'h8877_66AA, 32'h0000_0055, 1'b0);
    drive("lane1", 1'b1, 32'h0000_0101, 32'h0000_00AA, 32'h8877_6655,
          32'h0000_0100, 32'h8877_AA55, 32'h0000_0066, 1'b0);
    drive("lane2", 1'b1, 32'h0000_0102, 32'h0000_00AA, 32'h8877_6655,
          32'h0000_0100, 32'h88AA_6655, 32'h0000_0077, 1'b0);
    drive("lane3", 1'b1, 32'h0000_0103, 32'h0000_00AA, 32'h8877_6655,
          32'h0000_0100, 32'hAA77_6655, 32'h0000_0088, 1'b0);
    drive("byte_upper_din1", 1'b1, 32'h0000_2002, 32'hFFFF_FF3C, 32'h0102_0304,
          32'h0000_2000, 32'h013C_0304, 32'h0000_0002, 1'b0);
    drive("wrap", 1'b1, 32'hFFFF_FFFF, 32'h0000_00CD, 32'h1122_3344,
          32'hFFFF_FFFC, 32'hCD22_3344, 32'h0000_0011, 1'b0);

    drive("word_misaligned", 1'b0, 32'h0000_1002, 32'hA5A5_A5A5, 32'h5A5A_5A5A,
          32'h0000_1002, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
    drive("sticky_set", 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 32'h5A5A_5A5A,
          32'h0000_1000, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);
    drive("sticky_hold", 1'b0, 32'h0000_1000, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
          32'h0000_1000, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0);
    drive("word_misaligned_3", 1'b0, 32'h0000_0003, 32'h0000_0001, 32'h0000_0002,
          32'h0000_0003, 32'h0000_0001, 32'h0000_0002, 1'b1);

    drop_reset("reset_async_clear");
    drive("reset_hold_err", 1'b0, 32'h0000_1002, 32'h1111_1111, 32'h2222_2222,
          32'h0000_1002, 32'h1111_1111, 32'h2222_2222, 1'b1);
    drive("reset_hold_err2", 1'b0, 32'h0000_1002, 32'h1111_1111, 32'h2222_2222,
          32'h0000_1002, 32'h1111_1111, 32'h2222_2222, 1'b1);
    drive("reset_aligned", 1'b0, 32'h0000_1000, 32'h1111_1111, 32'h2222_2222,
          32'h0000_1000, 32'h1111_1111, 32'h2222_2222, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive("after_release", 1'b1, 32'h0000_1001, 32'h0000_0099, 32'h4433_2211,
          32'h0000_1000, 32'h4433_9911, 32'h0000_0022, 1'b0);
    drive("after_release2", 1'b0, 32'h0000_1004, 32'h0000_0099, 32'h4433_2211,
          32'h0000_1004, 32'h0000_0099, 32'h4433_2211, 1'b0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
